// File: rtl/id_decode_stage_pkg.sv
// Shared constants for the instruction-decode stage: opcodes, NOP encoding,
// instruction field positions and a register-dependency helper.
package id_decode_stage_pkg;

  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [5:0]  OP_BNE    = 6'h05;
  localparam logic [5:0]  OP_J      = 6'h02;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int REG_AW    = 5;

  typedef enum logic [1:0] {
    CTL_NONE   = 2'd0,
    CTL_BRANCH = 2'd1,
    CTL_JUMP   = 2'd2
  } ctl_kind_e;

  // True when a producer destination is a real register read by rs or rt.
  function automatic logic depends(input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rt);
    return (dst != '0) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/id_decode_stage_reg_file.sv
// 32-entry register file: synchronous write, combinational read with
// write-through bypass so a same-cycle writeback is visible to decode.
module id_decode_stage_reg_file
  import id_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [32];

  // r0 is never written, so its storage stays at the reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != '0)
      o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    if (i_raddr2 != '0)
      o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: IF/ID register, register file, early branch/jump
// resolution and load-use / branch-dependency stall detection.
module id_decode_stage #(
  parameter int                PC_W      = 10,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = id_decode_stage_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc_plus4,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              idex_mem_read,
  input  logic              idex_reg_write,
  input  logic [4:0]        idex_write_reg,
  input  logic              exmem_mem_read,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_write_reg,
  input  logic [DATA_W-1:0] exmem_alu_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              pc_en,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_address,
  output logic              jump,
  output logic [PC_W-1:0]   jump_address,
  output logic              id_bubble,
  output logic [DATA_W-1:0] id_instr,
  output logic [PC_W-1:0]   id_pc_plus4,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [DATA_W-1:0] imm_sext
);

  import id_decode_stage_pkg::*;

  logic [DATA_W-1:0] r_instr;
  logic [PC_W-1:0]   r_pcPlus4;

  logic [5:0]        w_opcode;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  ctl_kind_e         w_ctlKind;
  logic              w_stall;
  logic              w_loadUse;
  logic              w_branchDep;
  logic [DATA_W-1:0] w_cmpA;
  logic [DATA_W-1:0] w_cmpB;
  logic              w_branchCond;
  logic [PC_W-1:0]   w_brOffset;

  assign w_opcode = r_instr[OPCODE_HI:OPCODE_LO];
  assign w_rs     = r_instr[RS_HI:RS_LO];
  assign w_rt     = r_instr[RT_HI:RT_LO];

  always_comb begin
    w_ctlKind = CTL_NONE;
    if ((w_opcode == OP_BEQ) || (w_opcode == OP_BNE)) w_ctlKind = CTL_BRANCH;
    else if (w_opcode == OP_J)                        w_ctlKind = CTL_JUMP;
  end

  id_decode_stage_reg_file #(
    .DATA_W (DATA_W)
  ) u_regFile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wb_reg_write),
    .i_waddr  (wb_write_reg),
    .i_wdata  (wb_write_data),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (reg1_data),
    .o_rdata2 (reg2_data)
  );

  // Branches resolve here, so they must wait for any EX result and for MEM loads.
  always_comb begin
    w_loadUse   = idex_mem_read && depends(idex_write_reg, w_rs, w_rt);
    w_branchDep = (w_ctlKind == CTL_BRANCH) &&
                  ((idex_reg_write && depends(idex_write_reg, w_rs, w_rt)) ||
                   (exmem_mem_read && depends(exmem_write_reg, w_rs, w_rt)));
    w_stall     = w_loadUse || w_branchDep;
  end

  // A MEM-stage ALU result is newer than the register file for the compare.
  always_comb begin
    w_cmpA = reg1_data;
    w_cmpB = reg2_data;
    if (exmem_reg_write && !exmem_mem_read && (exmem_write_reg != '0)) begin
      if (exmem_write_reg == w_rs) w_cmpA = exmem_alu_result;
      if (exmem_write_reg == w_rt) w_cmpB = exmem_alu_result;
    end
  end

  assign w_branchCond = ((w_opcode == OP_BEQ) && (w_cmpA == w_cmpB)) ||
                        ((w_opcode == OP_BNE) && (w_cmpA != w_cmpB));

  assign imm_sext       = {{(DATA_W-16){r_instr[IMM_HI]}}, r_instr[IMM_HI:IMM_LO]};
  assign w_brOffset     = {imm_sext[PC_W-3:0], 2'b00};
  assign branch_address = r_pcPlus4 + w_brOffset;
  assign jump_address   = PC_W'({r_instr[7:0], 2'b00});

  assign pc_en        = !w_stall;
  assign id_bubble    = w_stall;
  assign branch_taken = !w_stall && w_branchCond;
  assign jump         = !w_stall && (w_ctlKind == CTL_JUMP);

  assign id_instr    = r_instr;
  assign id_pc_plus4 = r_pcPlus4;

  // Stall holds IF/ID; a redirect replaces the wrong-path fetch with a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= '0;
    end else if (!w_stall) begin
      r_instr   <= (branch_taken || jump) ? NOP_INSTR : if_instr;
      r_pcPlus4 <= if_pc_plus4;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: stimulus queues hand-computed expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_id_decode_stage;

  localparam int PC_W   = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   if_pc_plus4;
  logic [DATA_W-1:0] if_instr;
  logic              idex_mem_read, idex_reg_write;
  logic [4:0]        idex_write_reg;
  logic              exmem_mem_read, exmem_reg_write;
  logic [4:0]        exmem_write_reg;
  logic [DATA_W-1:0] exmem_alu_result;
  logic              wb_reg_write;
  logic [4:0]        wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic              pc_en, branch_taken, jump, id_bubble;
  logic [PC_W-1:0]   branch_address, jump_address, id_pc_plus4;
  logic [DATA_W-1:0] id_instr, reg1_data, reg2_data, imm_sext;

  id_decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc_plus4      (if_pc_plus4),
    .if_instr         (if_instr),
    .idex_mem_read    (idex_mem_read),
    .idex_reg_write   (idex_reg_write),
    .idex_write_reg   (idex_write_reg),
    .exmem_mem_read   (exmem_mem_read),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_write_reg  (exmem_write_reg),
    .exmem_alu_result (exmem_alu_result),
    .wb_reg_write     (wb_reg_write),
    .wb_write_reg     (wb_write_reg),
    .wb_write_data    (wb_write_data),
    .pc_en            (pc_en),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .jump             (jump),
    .jump_address     (jump_address),
    .id_bubble        (id_bubble),
    .id_instr         (id_instr),
    .id_pc_plus4      (id_pc_plus4),
    .reg1_data        (reg1_data),
    .reg2_data        (reg2_data),
    .imm_sext         (imm_sext)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_PCEN, S_BUBBLE, S_BRANCH, S_BRADDR, S_JUMP, S_JADDR,
    S_INSTR, S_PC4, S_REG1, S_REG2, S_IMM
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        expQ[$];
  exp_t        curExp;
  logic [31:0] curAct;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_PCEN:   return {31'd0, pc_en};
      S_BUBBLE: return {31'd0, id_bubble};
      S_BRANCH: return {31'd0, branch_taken};
      S_BRADDR: return {22'd0, branch_address};
      S_JUMP:   return {31'd0, jump};
      S_JADDR:  return {22'd0, jump_address};
      S_INSTR:  return id_instr;
      S_PC4:    return {22'd0, id_pc_plus4};
      S_REG1:   return reg1_data;
      S_REG2:   return reg2_data;
      default:  return imm_sext;
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc == cyc) begin
      curExp = expQ.pop_front();
      curAct = actual(curExp.sig);
      total++;
      if (curAct !== curExp.val) begin
        bad++;
        $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                 curExp.name, curAct, curExp.val, cyc);
      end
    end
  end

  task automatic checkOutput(input sig_e s, input logic [31:0] v, input string n);
    expQ.push_back('{cyc, s, v, n});
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] instr, input logic [PC_W-1:0] pc4);
    @(posedge clk);
    #1;
    if_instr    = instr;
    if_pc_plus4 = pc4;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    if_instr = '0; if_pc_plus4 = '0;
    idex_mem_read = 0; idex_reg_write = 0; idex_write_reg = '0;
    exmem_mem_read = 0; exmem_reg_write = 0; exmem_write_reg = '0; exmem_alu_result = '0;
    wb_reg_write = 0; wb_write_reg = '0; wb_write_data = '0;

    applyStimulus(32'h0, 10'd0);
    applyStimulus(32'h0, 10'd0);

    // Out of reset: IF/ID holds NOP; present lw and write r1 = 5 via WB.
    applyStimulus(32'h8C01_0000, 10'd4);
    reset = 1'b0;
    wb_reg_write = 1; wb_write_reg = 5'd1; wb_write_data = 32'd5;
    checkOutput(S_INSTR, 32'h0, "reset_instr");
    checkOutput(S_PC4, 32'd0, "reset_pc4");
    checkOutput(S_PCEN, 32'd1, "reset_pc_en");
    checkOutput(S_BUBBLE, 32'd0, "reset_bubble");

    applyStimulus(32'h0022_1820, 10'd8);
    wb_write_reg = 5'd2; wb_write_data = 32'd5;
    checkOutput(S_INSTR, 32'h8C01_0000, "fetch_instr");
    checkOutput(S_PC4, 32'd4, "fetch_pc4");
    checkOutput(S_REG2, 32'd5, "fetch_r1_read");

    // Load to r1 in EX while add r3,r1,r2 decodes.
    applyStimulus(32'h1022_0003, 10'd20);
    wb_reg_write = 0;
    idex_mem_read = 1; idex_reg_write = 1; idex_write_reg = 5'd1;
    checkOutput(S_INSTR, 32'h0022_1820, "lu_instr");
    checkOutput(S_PCEN, 32'd0, "lu_pc_en");
    checkOutput(S_BUBBLE, 32'd1, "lu_bubble");
    checkOutput(S_REG1, 32'd5, "lu_reg1");
    checkOutput(S_REG2, 32'd5, "lu_reg2");

    applyStimulus(32'h1022_0003, 10'd20);
    idex_mem_read = 0; idex_reg_write = 0; idex_write_reg = '0;
    checkOutput(S_INSTR, 32'h0022_1820, "lu_hold_instr");
    checkOutput(S_PCEN, 32'd1, "lu_resume_pc_en");
    checkOutput(S_BUBBLE, 32'd0, "lu_resume_bubble");

    // beq r1,r2,+3 with equal operands.
    applyStimulus(32'hAAAA_AAAA, 10'd24);
    checkOutput(S_INSTR, 32'h1022_0003, "beq_instr");
    checkOutput(S_BRANCH, 32'd1, "beq_taken");
    checkOutput(S_BRADDR, 32'd32, "beq_addr");
    checkOutput(S_IMM, 32'd3, "beq_imm");
    checkOutput(S_PC4, 32'd20, "beq_pc4");

    applyStimulus(32'h1422_0001, 10'd40);
    checkOutput(S_INSTR, 32'h0, "beq_flush_instr");
    checkOutput(S_PC4, 32'd24, "beq_flush_pc4");
    checkOutput(S_BRANCH, 32'd0, "beq_flush_taken");

    // bne r1,r2 while EX writes r2: stall, then forward 7 from MEM.
    applyStimulus(32'hBBBB_BBBB, 10'd44);
    idex_reg_write = 1; idex_write_reg = 5'd2;
    checkOutput(S_INSTR, 32'h1422_0001, "bne_instr");
    checkOutput(S_PCEN, 32'd0, "bne_stall_pc_en");
    checkOutput(S_BUBBLE, 32'd1, "bne_stall_bubble");
    checkOutput(S_BRANCH, 32'd0, "bne_stall_taken");

    applyStimulus(32'hBBBB_BBBB, 10'd44);
    idex_reg_write = 0; idex_write_reg = '0;
    exmem_reg_write = 1; exmem_write_reg = 5'd2; exmem_alu_result = 32'd7;
    checkOutput(S_INSTR, 32'h1422_0001, "bne_hold_instr");
    checkOutput(S_PC4, 32'd40, "bne_hold_pc4");
    checkOutput(S_BRANCH, 32'd1, "bne_fwd_taken");
    checkOutput(S_BRADDR, 32'd44, "bne_addr");
    checkOutput(S_REG2, 32'd5, "bne_reg2_unforwarded");
    checkOutput(S_PCEN, 32'd1, "bne_pc_en");

    applyStimulus(32'h0800_00FF, 10'd48);
    exmem_reg_write = 0; exmem_write_reg = '0; exmem_alu_result = '0;
    checkOutput(S_INSTR, 32'h0, "bne_flush_instr");
    checkOutput(S_PC4, 32'd44, "bne_flush_pc4");

    // j with instr[7:0] = FF.
    applyStimulus(32'hCCCC_CCCC, 10'd52);
    checkOutput(S_INSTR, 32'h0800_00FF, "j_instr");
    checkOutput(S_JUMP, 32'd1, "j_jump");
    checkOutput(S_JADDR, 32'h3FC, "j_addr");
    checkOutput(S_BRANCH, 32'd0, "j_no_branch");

    // beq r0,r0,+2 from PC+4 = 0x3FC wraps to 4.
    applyStimulus(32'h1000_0002, 10'h3FC);
    checkOutput(S_INSTR, 32'h0, "j_flush_instr");
    checkOutput(S_JUMP, 32'd0, "j_flush_jump");
    checkOutput(S_PC4, 32'd52, "j_flush_pc4");

    applyStimulus(32'h0080_0000, 10'd8);
    checkOutput(S_BRANCH, 32'd1, "wrap_taken");
    checkOutput(S_BRADDR, 32'd4, "wrap_addr");
    checkOutput(S_PC4, 32'h3FC, "wrap_pc4");

    applyStimulus(32'h0080_0000, 10'd8);
    checkOutput(S_INSTR, 32'h0, "wrap_flush_instr");

    // WB write-through to r4 while rs = r4 decodes.
    applyStimulus(32'h0080_0000, 10'd8);
    wb_reg_write = 1; wb_write_reg = 5'd4; wb_write_data = 32'hDEAD_BEEF;
    checkOutput(S_INSTR, 32'h0080_0000, "bypass_instr");
    checkOutput(S_REG1, 32'hDEAD_BEEF, "bypass_reg1");
    checkOutput(S_REG2, 32'h0, "bypass_reg2_r0");

    applyStimulus(32'h0080_0000, 10'd8);
    wb_write_reg = 5'd0; wb_write_data = 32'h1234_5678;
    checkOutput(S_REG1, 32'hDEAD_BEEF, "r4_stored");
    checkOutput(S_REG2, 32'h0, "r0_write_bypass");

    // Reset asserted during a load-use stall.
    applyStimulus(32'h0080_0000, 10'd8);
    wb_reg_write = 0; wb_write_reg = '0; wb_write_data = '0;
    idex_mem_read = 1; idex_write_reg = 5'd4;
    reset = 1'b1;
    checkOutput(S_REG2, 32'h0, "r0_after_write");
    checkOutput(S_PCEN, 32'd0, "rst_stall_pc_en");
    checkOutput(S_BUBBLE, 32'd1, "rst_stall_bubble");

    applyStimulus(32'h0080_0000, 10'd8);
    reset = 1'b0;
    checkOutput(S_INSTR, 32'h0, "rst_release_instr");
    checkOutput(S_PCEN, 32'd1, "rst_release_pc_en");
    checkOutput(S_BUBBLE, 32'd0, "rst_release_bubble");

    applyStimulus(32'h0080_0000, 10'd8);
    idex_mem_read = 0; idex_write_reg = '0;
    checkOutput(S_INSTR, 32'h0080_0000, "post_rst_instr");
    checkOutput(S_REG1, 32'h0, "post_rst_r4_cleared");

    @(posedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
